// File: rtl/prog_launcher.sv
// Host-side launcher: fires one Start pulse per program, times each run
// until Done, and aborts a run that exceeds TIMEOUT cycles.
module prog_launcher #(
   parameter int            NUM_PROGS = 3,
   parameter int            CW        = 16,
   parameter logic [CW-1:0] TIMEOUT   = 16'd50000
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic          Done,
   output logic          Start,
   output logic          Busy,
   output logic [1:0]    ProgIdx,
   output logic [CW-1:0] CycleCount,
   output logic          CountValid,
   output logic          AllDone,
   output logic          Timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_DRAIN,
      S_FINISH
   } state_t;

   localparam logic [1:0] LAST = 2'(NUM_PROGS - 1);

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          last;
   logic          to_hit;

   assign cnt_inc = cnt + CW'(1);
   assign last    = (ProgIdx == LAST);
   assign to_hit  = (cnt_inc == TIMEOUT);

   always_ff @(posedge Clk) begin
      if (Reset) state <= S_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:   if (Go) nxt = S_LAUNCH;
         S_LAUNCH: nxt = S_RUN;
         S_RUN: begin
            // Done takes priority over a coincident timeout
            if (Done)        nxt = S_DRAIN;
            else if (to_hit) nxt = S_FINISH;
         end
         S_DRAIN:  if (!Done) nxt = last ? S_FINISH : S_LAUNCH;
         S_FINISH: nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         Start      <= 1'b0;
         Busy       <= 1'b0;
         ProgIdx    <= 2'd0;
         CycleCount <= '0;
         CountValid <= 1'b0;
         AllDone    <= 1'b0;
         Timeout    <= 1'b0;
         cnt        <= '0;
      end else begin
         Start      <= (nxt == S_LAUNCH);
         Busy       <= (nxt != S_IDLE);
         CountValid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (Go) begin
                  AllDone <= 1'b0;
                  Timeout <= 1'b0;
                  ProgIdx <= 2'd0;
               end
            end
            S_LAUNCH: cnt <= '0;
            S_RUN: begin
               cnt <= cnt_inc;
               if (Done) begin
                  CycleCount <= cnt_inc;
                  CountValid <= 1'b1;
               end else if (to_hit) begin
                  CycleCount <= TIMEOUT;
                  CountValid <= 1'b1;
                  Timeout    <= 1'b1;
                  AllDone    <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (!Done) begin
                  if (last) AllDone <= 1'b1;
                  else      ProgIdx <= ProgIdx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
